// File: rtl/pwm_capture_int.sv
// pwm_capture_int: measures high time and period of an asynchronous PWM input and raises a
// sticky interrupt on over-range duty or a stuck input. Define PWM_CAP_FILTER_EN for the deglitch filter.
module pwm_capture_int #(
    parameter int unsigned CNT_WIDTH   = 20,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_HIGH    = 990000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PWM_in,
    input  logic                 IntClear,
    output logic [CNT_WIDTH-1:0] HighTime,
    output logic [CNT_WIDTH-1:0] Period,
    output logic                 Valid,
    output logic                 Interrupt,
    output logic [1:0]           IntCause
);

`ifdef PWM_CAP_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int unsigned          FW       = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] HIGH_LIM = CNT_WIDTH'(MAX_HIGH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   s_d_q;
    logic                   raw, s, rise, fall;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hi_lat_q, hi_lat_d;
    logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   int_q, int_d;
    logic [1:0]             cause_q, cause_d;
    logic [1:0]             set_v;

    assign raw = sync_q[SYNC_STAGES-1];

    // Deglitch: follow raw only after it has differed from the filtered value FILTER_LEN cycles
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], PWM_in};
        filt_d = filt_q;
        fcnt_d = '0;
        if (raw != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = raw;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    assign s    = FILT_EN ? filt_q : raw;
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // Measurement FSM; timeout has priority over an edge seen on the same cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        set_v       = 2'b00;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == CNT_MAX) begin
                    set_v[1] = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = LOW;
                    end
                end
            end
            LOW: begin
                if (cnt_q == CNT_MAX) begin
                    set_v[1] = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (rise) begin
                    high_time_d = hi_lat_q;
                    period_d    = cnt_q;
                    valid_d     = 1'b1;
                    set_v[0]    = (hi_lat_q > HIGH_LIM);
                    cnt_d       = CNT_WIDTH'(1);
                    state_d     = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // A cause raised on the clearing cycle survives the clear
        cause_d = IntClear ? set_v : (cause_q | set_v);
        int_d   = IntClear ? (|set_v) : (int_q | (|set_v));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            fcnt_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            s_d_q  <= s;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            int_q       <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            int_q       <= int_d;
            cause_q     <= cause_d;
        end
    end

    assign HighTime  = high_time_q;
    assign Period    = period_q;
    assign Valid     = valid_q;
    assign Interrupt = int_q;
    assign IntCause  = cause_q;

endmodule
